// File: rtl/fan_pwm_ctrl_mc.sv
// fan_pwm_ctrl_mc: multi-channel fan PWM with shared period, soft-start duty ramp and tach stall detection
//   clk, reset_n       : clock, asynchronous active-low reset (fans full on while in reset)
//   cfg_load_i         : strobe capturing period_i / duty_tgt_i, applied at the next period wrap
//   period_i           : PWM period in clk cycles (values below 2 are treated as 2)
//   duty_tgt_i         : per-channel target duty, channel c at [c*CNT_W +: CNT_W]
//   tach_i             : asynchronous tach pulses, one per channel
//   fan_pwm_o          : registered PWM drive per channel
//   period_start_o     : high in the cycle the period counter is 0
//   tach_cnt_o         : rising-edge count of the last completed window, 16 bits per channel
//   tach_valid_o       : one-cycle pulse when tach_cnt_o / stall_o update
//   stall_o            : per-channel stall flag, forces that fan to full drive
module fan_pwm_ctrl_mc #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 14,
  parameter int PERIOD_DEF = 10000,
  parameter int DUTY_DEF   = 6000,
  parameter int RAMP_STEP  = 100,
  parameter int TACH_WIN   = 100,
  parameter int STALL_MIN  = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_load_i,
  input  logic [CNT_W-1:0]        period_i,
  input  logic [NUM_CH*CNT_W-1:0] duty_tgt_i,
  input  logic [NUM_CH-1:0]       tach_i,
  output logic [NUM_CH-1:0]       fan_pwm_o,
  output logic                    period_start_o,
  output logic [NUM_CH*16-1:0]    tach_cnt_o,
  output logic                    tach_valid_o,
  output logic [NUM_CH-1:0]       stall_o
);
  localparam int WIN_W = $clog2(TACH_WIN + 1);
  localparam logic [CNT_W:0] STEP = (CNT_W+1)'(RAMP_STEP);
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, pend_period_q, pend_period_d;
  logic [NUM_CH-1:0][CNT_W-1:0] tgt_q, tgt_d, pend_tgt_q, pend_tgt_d, cur_q, cur_d;
  logic [NUM_CH-1:0][15:0] tcnt_q, tcnt_d, tout_q, tout_d;
  logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [NUM_CH-1:0] stall_q, stall_d, pwm_q, pwm_d, rise;
  logic [WIN_W-1:0] win_q, win_d;
  logic pstart_q, pstart_d, tvalid_q, tvalid_d, wrap, win_end;

  // Move cur toward tgt by at most STEP, then clamp to the period; one extra bit keeps the math wrap-free.
  function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] cur, tgt, per);
    logic [CNT_W:0] cw, tw, nw;
    cw = {1'b0, cur};
    tw = {1'b0, tgt};
    nw = (tw > cw) ? ((tw - cw > STEP) ? cw + STEP : tw) : ((cw - tw > STEP) ? cw - STEP : tw);
    return (nw > {1'b0, per}) ? per : nw[CNT_W-1:0];
  endfunction

  always_comb begin
    wrap          = cnt_q >= period_q - 1'b1;
    win_end       = wrap && (win_q == WIN_W'(TACH_WIN - 1));
    cnt_d         = wrap ? '0 : cnt_q + 1'b1;
    // Pending registers always hold the values to use from the next wrap; a strobe in the
    // last cycle of a period lands after that wrap has already consumed the old pending values.
    pend_period_d = cfg_load_i ? ((period_i < CNT_W'(2)) ? CNT_W'(2) : period_i) : pend_period_q;
    pend_tgt_d    = cfg_load_i ? duty_tgt_i : pend_tgt_q;
    period_d      = wrap ? pend_period_q : period_q;
    tgt_d         = wrap ? pend_tgt_q : tgt_q;
    win_d         = wrap ? (win_end ? '0 : win_q + 1'b1) : win_q;
    sync1_d       = tach_i;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    rise          = sync2_q & ~prev_q;
    pstart_d      = wrap;
    tvalid_d      = win_end;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_d[i]   = wrap ? ramp(cur_q[i], tgt_d[i], period_d) : cur_q[i];
      tout_d[i]  = win_end ? tcnt_q[i] : tout_q[i];
      stall_d[i] = win_end ? (tcnt_q[i] < 16'(STALL_MIN)) : stall_q[i];
      // The clear cycle restarts at the edge seen in that cycle so no edge is lost.
      tcnt_d[i]  = win_end ? 16'(rise[i]) : (rise[i] && tcnt_q[i] != 16'hFFFF) ? tcnt_q[i] + 1'b1 : tcnt_q[i];
      // Compare against next-cycle state so the registered output matches cnt exactly.
      pwm_d[i]   = cnt_d < (stall_d[i] ? period_d : cur_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      period_q      <= CNT_W'(PERIOD_DEF);
      pend_period_q <= CNT_W'(PERIOD_DEF);
      tgt_q         <= {NUM_CH{CNT_W'(DUTY_DEF)}};
      pend_tgt_q    <= {NUM_CH{CNT_W'(DUTY_DEF)}};
      cur_q         <= {NUM_CH{CNT_W'(DUTY_DEF)}};
      tcnt_q        <= '0;
      tout_q        <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      stall_q       <= '0;
      pwm_q         <= '1;
      win_q         <= '0;
      pstart_q      <= 1'b0;
      tvalid_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      pend_period_q <= pend_period_d;
      tgt_q         <= tgt_d;
      pend_tgt_q    <= pend_tgt_d;
      cur_q         <= cur_d;
      tcnt_q        <= tcnt_d;
      tout_q        <= tout_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      stall_q       <= stall_d;
      pwm_q         <= pwm_d;
      win_q         <= win_d;
      pstart_q      <= pstart_d;
      tvalid_q      <= tvalid_d;
    end
  end

  assign fan_pwm_o      = pwm_q;
  assign period_start_o = pstart_q;
  assign tach_cnt_o     = tout_q;
  assign tach_valid_o   = tvalid_q;
  assign stall_o        = stall_q;
endmodule

// File: tb/tb_fan_pwm_ctrl_mc.sv
// tb_fan_pwm_ctrl_mc: randomized scenarios checked against a period-level behavioural model
module tb_fan_pwm_ctrl_mc;
  localparam int N = 2;
  localparam int W = 14;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cfg_load_i = 1'b0;
  logic [W-1:0] period_i = '0;
  logic [N*W-1:0] duty_tgt_i = '0;
  logic [N-1:0] tach_i = '0;
  logic [N-1:0] fan_pwm_o, stall_o;
  logic period_start_o, tach_valid_o;
  logic [N*16-1:0] tach_cnt_o;

  fan_pwm_ctrl_mc dut (
    .clk(clk), .reset_n(reset_n), .cfg_load_i(cfg_load_i), .period_i(period_i),
    .duty_tgt_i(duty_tgt_i), .tach_i(tach_i), .fan_pwm_o(fan_pwm_o),
    .period_start_o(period_start_o), .tach_cnt_o(tach_cnt_o),
    .tach_valid_o(tach_valid_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int m_pos, m_period, m_pend_p, m_win;
  bit m_first, m_valid;
  int m_cur[N], m_tgt[N], m_pend_t[N], m_count[N], m_tout[N];
  bit m_stall[N];
  int acc_len, last_len, acc_hi[N], last_hi[N];
  int pwm_err, ps_err, tv_err, st_err;
  bit t_en[N];
  int t_half[N], t_ph[N], t_budget[N];

  task automatic model_reset();
    m_pos = 0; m_period = 10000; m_pend_p = 10000; m_win = 0; m_first = 1; m_valid = 0;
    pwm_err = 0; ps_err = 0; tv_err = 0; st_err = 0; acc_len = 0; last_len = 0;
    for (int c = 0; c < N; c++) begin
      m_cur[c] = 6000; m_tgt[c] = 6000; m_pend_t[c] = 6000;
      m_count[c] = 0; m_tout[c] = 0; m_stall[c] = 0; acc_hi[c] = 0; last_hi[c] = 0;
    end
  endtask

  // One clock: advance the model by the period rules, then sample the DUT against it.
  task automatic tick();
    int d, e;
    @(posedge clk);
    m_valid = 0;
    if (m_pos == m_period - 1) begin
      m_pos = 0; m_first = 0; m_period = m_pend_p;
      for (int c = 0; c < N; c++) begin
        m_tgt[c] = m_pend_t[c];
        d = m_tgt[c] - m_cur[c];
        d = d > 100 ? 100 : (d < -100 ? -100 : d);
        m_cur[c] = m_cur[c] + d > m_period ? m_period : m_cur[c] + d;
      end
      m_win++;
      if (m_win == 100) begin
        m_win = 0; m_valid = 1;
        for (int c = 0; c < N; c++) begin
          m_tout[c] = m_count[c]; m_stall[c] = m_count[c] < 1; m_count[c] = 0;
        end
      end
      last_len = acc_len; last_hi = acc_hi; acc_len = 0;
      for (int c = 0; c < N; c++) acc_hi[c] = 0;
    end else m_pos++;
    if (cfg_load_i) begin
      m_pend_p = period_i < 2 ? 2 : int'(period_i);
      for (int c = 0; c < N; c++) m_pend_t[c] = int'(duty_tgt_i[c*W +: W]);
    end
    #1;
    acc_len++;
    for (int c = 0; c < N; c++) begin
      e = m_stall[c] ? m_period : m_cur[c];
      if (fan_pwm_o[c] !== (m_pos < e)) pwm_err++;
      if (stall_o[c] !== m_stall[c]) st_err++;
      acc_hi[c] += int'(fan_pwm_o[c]);
    end
    if (period_start_o !== (m_pos == 0 && !m_first)) ps_err++;
    if (tach_valid_o !== m_valid) tv_err++;
    // Tach edges only well inside a period so the synchroniser delay never straddles a window end.
    for (int c = 0; c < N; c++) begin
      t_ph[c]++;
      if (t_en[c] && t_ph[c] >= t_half[c] && m_pos >= 3 && m_pos <= m_period - 6 && (tach_i[c] || t_budget[c] != 0)) begin
        t_ph[c] = 0;
        if (!tach_i[c]) begin
          if (t_budget[c] > 0) t_budget[c]--;
          if (m_count[c] < 65535) m_count[c]++;
        end
        tach_i[c] = ~tach_i[c];
      end
    end
  endtask

  task automatic cfg(input int p, input int t0, input int t1);
    cfg_load_i = 1'b1; period_i = W'(p); duty_tgt_i = {W'(t1), W'(t0)};
    tick();
    cfg_load_i = 1'b0;
  endtask

  task automatic run_to_wrap();
    do tick(); while (m_pos != 0);
  endtask

  task automatic run_to_valid(input string tag);
    int k = 0;
    do begin tick(); k++; end while (!m_valid && k < 10000);
    if (!m_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: no window end after %0d cycles, want one", tag, k);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1;
    acc_len = 1;
    for (int c = 0; c < N; c++) acc_hi[c] = int'(fan_pwm_o[c]);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks += 5;
    if (fan_pwm_o !== 2'b11) begin n_fail++; $display("FAIL reset_pwm: got %b want 11", fan_pwm_o); end
    if (stall_o !== 2'b00) begin n_fail++; $display("FAIL reset_stall: got %b want 00", stall_o); end
    if (tach_cnt_o !== '0) begin n_fail++; $display("FAIL reset_tach_cnt: got %h want 0", tach_cnt_o); end
    if (tach_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tach_valid: got %b want 0", tach_valid_o); end
    if (period_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_period_start: got %b want 0", period_start_o); end
    release_reset();
    n_checks++;
    if (fan_pwm_o !== 2'b11) begin n_fail++; $display("FAIL release_pwm: got %b want 11", fan_pwm_o); end
  endtask

  task automatic test_default();
    for (int c = 0; c < N; c++) begin t_en[c] = 1; t_half[c] = 500; t_budget[c] = -1; end
    run_to_wrap();
    n_checks += 3;
    if (last_len !== 10000) begin n_fail++; $display("FAIL default_len: got %0d want 10000", last_len); end
    if (last_hi[0] !== 6000 || last_hi[1] !== 6000) begin n_fail++; $display("FAIL default_hi: got %0d/%0d want 6000/6000", last_hi[0], last_hi[1]); end
    if ((pwm_err | ps_err | tv_err | st_err) !== 0) begin n_fail++; $display("FAIL default_cycles: pwm=%0d ps=%0d tv=%0d st=%0d disagreements, want 0", pwm_err, ps_err, tv_err, st_err); end
  endtask

  task automatic test_ramp();
    int exp_hi;
    cfg(1000, 500, 500);
    run_to_wrap();
    n_checks++;
    if (last_len !== 10000) begin n_fail++; $display("FAIL ramp_old_len: got %0d want 10000", last_len); end
    for (int k = 0; k < 7; k++) begin
      run_to_wrap();
      exp_hi = 1000 - 100 * k < 500 ? 500 : 1000 - 100 * k;
      n_checks++;
      if (last_hi[0] !== exp_hi || last_hi[1] !== exp_hi || last_len !== 1000)
        begin n_fail++; $display("FAIL ramp_step%0d: got hi %0d/%0d len %0d want hi %0d len 1000", k, last_hi[0], last_hi[1], last_len, exp_hi); end
    end
  endtask

  task automatic test_extremes();
    cfg(1000, 0, 1000);
    repeat (7) run_to_wrap();
    n_checks += 3;
    if (last_hi[0] !== 0 || last_hi[1] !== 1000) begin n_fail++; $display("FAIL extremes_hi: got %0d/%0d want 0/1000", last_hi[0], last_hi[1]); end
    if (fan_pwm_o !== 2'b10) begin n_fail++; $display("FAIL extremes_wrap: got %b want 10", fan_pwm_o); end
    if ((pwm_err | ps_err | tv_err | st_err) !== 0) begin n_fail++; $display("FAIL extremes_cycles: pwm=%0d ps=%0d tv=%0d st=%0d disagreements, want 0", pwm_err, ps_err, tv_err, st_err); end
  endtask

  task automatic test_tach_stall();
    cfg(40, 20, 20);
    run_to_valid("win1");
    n_checks += 3;
    if (tach_valid_o !== 1'b1) begin n_fail++; $display("FAIL win1_valid: got %b want 1", tach_valid_o); end
    if (tach_cnt_o !== {16'(m_tout[1]), 16'(m_tout[0])}) begin n_fail++; $display("FAIL win1_cnt: got %h want %04h%04h", tach_cnt_o, m_tout[1], m_tout[0]); end
    if (stall_o !== {m_stall[1], m_stall[0]}) begin n_fail++; $display("FAIL win1_stall: got %b want %b%b", stall_o, m_stall[1], m_stall[0]); end
    t_budget[0] = 37; t_half[0] = 6; t_en[1] = 0;
    tick();
    n_checks++;
    if (tach_valid_o !== 1'b0) begin n_fail++; $display("FAIL valid_width: got %b want 0", tach_valid_o); end
    run_to_valid("win2");
    n_checks += 2;
    if (tach_cnt_o !== {16'd0, 16'd37}) begin n_fail++; $display("FAIL win2_cnt: got %h want 00000025", tach_cnt_o); end
    if (stall_o !== 2'b10) begin n_fail++; $display("FAIL win2_stall: got %b want 10", stall_o); end
    t_budget[0] = -1; t_en[1] = 1; t_half[1] = int'($urandom_range(5, 15)); t_budget[1] = -1;
    run_to_wrap();
    n_checks++;
    if (last_hi[0] !== 20 || last_hi[1] !== 40) begin n_fail++; $display("FAIL stall_force: got %0d/%0d want 20/40", last_hi[0], last_hi[1]); end
    run_to_valid("win3");
    n_checks += 2;
    if (stall_o !== 2'b00) begin n_fail++; $display("FAIL win3_stall: got %b want 00", stall_o); end
    if (tach_cnt_o !== {16'(m_tout[1]), 16'(m_tout[0])}) begin n_fail++; $display("FAIL win3_cnt: got %h want %04h%04h", tach_cnt_o, m_tout[1], m_tout[0]); end
    run_to_wrap();
    n_checks += 2;
    if (last_hi[1] !== 20) begin n_fail++; $display("FAIL unstall_duty: got %0d want 20", last_hi[1]); end
    if ((pwm_err | ps_err | tv_err | st_err) !== 0) begin n_fail++; $display("FAIL tach_cycles: pwm=%0d ps=%0d tv=%0d st=%0d disagreements, want 0", pwm_err, ps_err, tv_err, st_err); end
  endtask

  task automatic test_back_to_back();
    cfg(1000, 200, 200);
    repeat (5) tick();
    cfg(1000, 800, 800);
    run_to_wrap();
    n_checks++;
    if (last_len !== 40) begin n_fail++; $display("FAIL b2b_no_midperiod: got len %0d want 40", last_len); end
    run_to_wrap();
    n_checks++;
    if (last_hi[0] !== 120 || last_len !== 1000) begin n_fail++; $display("FAIL b2b_first: got hi %0d len %0d want 120/1000", last_hi[0], last_len); end
    run_to_wrap();
    n_checks++;
    if (last_hi[0] !== 220 || last_hi[1] !== 220) begin n_fail++; $display("FAIL b2b_last_wins: got %0d/%0d want 220/220", last_hi[0], last_hi[1]); end
    while (m_pos != m_period - 1) tick();
    cfg(500, 800, 800);
    run_to_wrap();
    n_checks++;
    if (last_len !== 1000) begin n_fail++; $display("FAIL wrapcfg_deferred: got len %0d want 1000", last_len); end
    run_to_wrap();
    n_checks += 2;
    if (last_len !== 500) begin n_fail++; $display("FAIL wrapcfg_applied: got len %0d want 500", last_len); end
    if ((pwm_err | ps_err | tv_err | st_err) !== 0) begin n_fail++; $display("FAIL b2b_cycles: pwm=%0d ps=%0d tv=%0d st=%0d disagreements, want 0", pwm_err, ps_err, tv_err, st_err); end
  endtask

  task automatic test_random_cfg();
    int p, want;
    for (int i = 0; i < 6; i++) begin
      p = i == 0 ? 1 : int'($urandom_range(0, 150));
      want = p < 2 ? 2 : p;
      repeat (int'($urandom_range(0, 30))) tick();
      cfg(p, int'($urandom_range(0, 200)), int'($urandom_range(0, 200)));
      repeat (3) run_to_wrap();
      n_checks++;
      if (last_len !== want) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d (period_i %0d)", i, last_len, want, p); end
    end
    n_checks++;
    if ((pwm_err | ps_err | tv_err | st_err) !== 0) begin n_fail++; $display("FAIL rand_cycles: pwm=%0d ps=%0d tv=%0d st=%0d disagreements, want 0", pwm_err, ps_err, tv_err, st_err); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    for (int c = 0; c < N; c++) t_en[c] = 0;
    tach_i = '0;
    cfg(200, 0, 0);
    repeat (4) run_to_wrap();
    while (!(m_pos >= (m_stall[0] ? m_period : m_cur[0]) && m_pos >= (m_stall[1] ? m_period : m_cur[1])) && k < 1000) begin tick(); k++; end
    n_checks++;
    if (fan_pwm_o !== 2'b00) begin n_fail++; $display("FAIL mid_low: got %b want 00", fan_pwm_o); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (fan_pwm_o !== 2'b11) begin n_fail++; $display("FAIL mid_async: got %b want 11", fan_pwm_o); end
    repeat (2) @(posedge clk);
    release_reset();
    run_to_wrap();
    n_checks += 3;
    if (last_len !== 10000) begin n_fail++; $display("FAIL restart_len: got %0d want 10000", last_len); end
    if (last_hi[0] !== 6000 || last_hi[1] !== 6000) begin n_fail++; $display("FAIL restart_hi: got %0d/%0d want 6000/6000", last_hi[0], last_hi[1]); end
    if ((pwm_err | ps_err | tv_err | st_err) !== 0) begin n_fail++; $display("FAIL restart_cycles: pwm=%0d ps=%0d tv=%0d st=%0d disagreements, want 0", pwm_err, ps_err, tv_err, st_err); end
  endtask

  initial begin
    model_reset();
    for (int c = 0; c < N; c++) begin t_en[c] = 0; t_half[c] = 500; t_ph[c] = 0; t_budget[c] = -1; end
    test_reset();
    test_default();
    test_ramp();
    test_extremes();
    test_tach_stall();
    test_back_to_back();
    test_random_cfg();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fan_pwm_ctrl_mc.md
Name: fan_pwm_ctrl_mc

Overview:
Multi-channel fan PWM controller. It has a shared, runtime-programmable period, a per-channel target duty with soft-start ramping, and tachometer pulse counting with stall detection. A stalled fan is forced to full speed. The block sits beside board-management logic and drives the fan enable/PWM pins directly; it is fail-safe (fans full on) in reset.

Parameters:
NUM_CH, 2, number of fan channels
CNT_W, 14, width of period/duty counters
PERIOD_DEF, 10000, period in clk cycles used after reset until first cfg_load_i
DUTY_DEF, 6000, initial duty_cur and duty_tgt per channel after reset (high cycles per period)
RAMP_STEP, 100, max change of duty_cur per period
TACH_WIN, 100, tach measurement window, in PWM periods
STALL_MIN, 1, minimum tach rising edges per window for a fan to be considered running

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
cfg_load_i  in  1  one-cycle strobe: capture period_i and duty_tgt_i
period_i  in  CNT_W  new PWM period in clk cycles
duty_tgt_i  in  NUM_CH*CNT_W  per-channel target duty, channel c at [c*CNT_W +: CNT_W]
tach_i  in  NUM_CH  asynchronous tach pulses from fans
fan_pwm_o  out  NUM_CH  PWM output, 1 = fan drive on
period_start_o  out  1  high for one cycle at the start of each period (cnt==0)
tach_cnt_o  out  NUM_CH*16  last completed window's rising-edge count per channel
tach_valid_o  out  1  one-cycle pulse when tach_cnt_o/stall_o are updated
stall_o  out  NUM_CH  per-channel stall flag

Behaviour:
- Reset (async assert, sync-release-safe):
  - fan_pwm_o = all 1s, stall_o = 0, tach_cnt_o = 0, tach_valid_o = 0, period_start_o = 0.
  - cnt = 0, period_reg = PERIOD_DEF, duty_cur = duty_tgt_reg = DUTY_DEF, window counter = 0.
  - Assertion mid-period forces outputs to reset values immediately.
- Counter: cnt runs 0..period_reg-1, then wraps to 0. period_start_o = 1 in the cycle cnt==0.
- cfg_load_i: period_i and duty_tgt_i are captured into pending registers. Pending values are applied at the next wrap (cnt 0 of the following period), never mid-period.
  - A later strobe before the wrap overwrites the pending values.
  - period_i < 2 is applied as 2.
- Duty: duty_eff[c] = period_reg if stall_o[c], else duty_cur[c].
  - fan_pwm_o[c] = 1 in cycles where cnt < duty_eff[c]. It is registered and glitch-free.
  - duty_eff >= period_reg gives constant 1; duty_eff = 0 gives constant 0, with no one-cycle pulses at the wrap.
- Ramp: at each wrap, duty_cur[c] moves toward duty_tgt_reg[c] by min(RAMP_STEP, |difference|), then clamps to period_reg. Arithmetic is done at CNT_W+1 bits; there is no wrap-around/underflow.
- Tach:
  - tach_i is passed through a 2-flop synchroniser; rising edges of the synchronised signal are counted.
  - The counter saturates at 16'hFFFF.
  - The window ends at the wrap completing the TACH_WIN-th period. In that cycle:
    - tach_cnt_o[c] is loaded with the count;
    - stall_o[c] = (count < STALL_MIN);
    - tach_valid_o pulses;
    - counters clear.
  - An edge detected in the clear cycle counts toward the new window.
  - stall_o holds until the next window result. Clearing it returns the channel to duty_cur without re-ramping.
- Simultaneous cfg apply and window end in the same wrap: both take effect. The stall evaluation uses the completed window.

Test Plan:
- Reset, no cfg, PERIOD_DEF=10000, DUTY_DEF=6000, tach toggling every 500 cycles -> per channel: fan_pwm_o high 6000 cycles / low 4000 per period; period_start_o every 10000 cycles.
- cfg_load_i with period 1000, duty_tgt 500 -> new period from next wrap. duty_cur ramps 6000 → clamp 1000 → 900 → ... → 500, one step per period, never exceeding period.
- duty_tgt = 0 on ch0, 1000 on ch1 (period 1000) after ramp settles -> ch0 constant 0, ch1 constant 1, no glitch at wrap.
- Tach: ch0 gets 37 pulses, ch1 none, in a window (TACH_WIN=100) -> tach_valid_o one cycle, tach_cnt_o ch0=37, ch1=0. stall_o=2'b10, fan_pwm_o[1] constant 1; restoring ch1 pulses clears the stall at the next window end.
- cfg_load_i twice in one period (duty 200 then 800) -> only 800 applied at the wrap. cfg_load_i in the wrap cycle -> applied at the following wrap.
- reset_n asserted mid-period while outputs are low -> fan_pwm_o goes to 1 asynchronously; after release, timing restarts from PERIOD_DEF/DUTY_DEF.
